// File: rtl/mul_sched_pkg.sv
// ---------------------------------------------------------------------------
// Package: mul_sched_pkg
// Purpose: shared types and sizing helpers for the round-robin multiplier
//          scheduler (mul_rr_sched) and its arbiter (rr_arbiter).
// Contents:
//   state_t        FSM state encoding {IDLE, CALC, RESP}
//   NREQ_DEF       default number of requesters
//   WIDTH_DEF      default operand width
//   prod_w(w)      product width for a w x w unsigned multiply
// ---------------------------------------------------------------------------
package mul_sched_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // A full unsigned product never needs more than twice the operand width.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// Module: rr_arbiter
// Purpose: purely combinational round-robin pick. Grants the first asserted
//          request at or after the priority pointer, wrapping cyclically.
// Ports:
//   req           in   NREQ   request vector
//   ptr           in   IDW    index that currently has highest priority
//   grant_onehot  out  NREQ   one-hot grant (all zero when nothing requests)
//   grant_idx     out  IDW    binary index of the granted requester
//   any           out  1      at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    // Walk the requesters starting at ptr; the first hit wins. The modulo
    // keeps the search correct even when NREQ is not a power of two.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any             = 1'b1;
                grant_idx       = IDW'(j);
                grant_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_rr_sched.sv
// ---------------------------------------------------------------------------
// Module: mul_rr_sched
// Purpose: shares one registered WIDTH x WIDTH unsigned multiplier among NREQ
//          requesters. Requests are picked round-robin, one operation is in
//          flight at a time, and each product is returned on a single
//          valid/ready channel tagged with the owning requester's index.
// Ports:
//   clk          in   1            rising-edge clock
//   rst_n        in   1            synchronous reset, active-low
//   req_valid    in   NREQ         per-requester operand valid
//   req_a        in   NREQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   NREQ*WIDTH   operand B, same packing
//   req_ready    out  NREQ         registered one-hot accept pulse
//   rsp_valid    out  1            registered product-available flag
//   rsp_id       out  IDW          requester that owns rsp_product
//   rsp_product  out  2*WIDTH      full-width unsigned a*b
//   rsp_ready    in   1            consumer accepts the response
//   busy         out  1            FSM is not in IDLE
// Timing: grant decided in IDLE, operands latched on the IDLE->CALC edge
//         (req_ready pulses during CALC), product registered on the
//         CALC->RESP edge, response held until the rsp handshake.
// ---------------------------------------------------------------------------
module mul_rr_sched
    import mul_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_a,
    input  logic [NREQ*WIDTH-1:0]      req_b,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [prod_w(WIDTH)-1:0]   rsp_product,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int PW = prod_w(WIDTH);

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    ptr_nxt;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;

    logic [NREQ-1:0]   grant_onehot;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;

    logic [NREQ-1:0]   ready_nxt;
    logic              rsp_valid_nxt;
    logic              load_ops;
    logic              load_prod;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req          (req_valid),
        .ptr          (ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    // The winner's successor becomes the next highest-priority requester.
    assign ptr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one cycle each in IDLE (when something requests) and
    // CALC, then RESP until the consumer takes the product.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control logic: next values for the registered handshake outputs
    // and load enables for the operand and product registers.
    always_comb begin
        ready_nxt     = '0;
        rsp_valid_nxt = 1'b0;
        load_ops      = 1'b0;
        load_prod     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    ready_nxt = grant_onehot;
                    load_ops  = 1'b1;
                end
            end
            CALC: begin
                load_prod     = 1'b1;
                rsp_valid_nxt = 1'b1;
            end
            RESP: begin
                rsp_valid_nxt = !(rsp_valid && rsp_ready);
            end
            default: begin
                ready_nxt = '0;
            end
        endcase
    end

    // Datapath and registered outputs. A reset drops any in-flight operation,
    // so no response is ever issued for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            req_ready   <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            op_a        <= '0;
            op_b        <= '0;
        end else begin
            req_ready <= ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            if (load_ops) begin
                op_a   <= req_a[grant_idx*WIDTH +: WIDTH];
                op_b   <= req_b[grant_idx*WIDTH +: WIDTH];
                rsp_id <= grant_idx;
                ptr    <= ptr_nxt;
            end
            if (load_prod) begin
                rsp_product <= PW'(op_a) * PW'(op_b);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_rr_sched.sv
// ---------------------------------------------------------------------------
// Testbench: tb_mul_rr_sched
// Purpose: directed scenarios (reset, single op, round-robin order,
//          back-pressure, extreme operands, mid-operation reset) followed by
//          randomized traffic. A behavioural model tracks the pointer, the
//          pending operation and the cycles since each grant, and is compared
//          against the DUT at every falling edge.
// ---------------------------------------------------------------------------
module tb_mul_rr_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;
    localparam int PW    = 2 * WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [PW-1:0]         rsp_product;
    logic                  rsp_ready;
    logic                  busy;

    int num_checks = 0;
    int num_fail   = 0;

    int grant_log[$];

    mul_rr_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy,
                                 input int cycles);
        req_valid = valid;
        rsp_ready = rdy;
        for (int c = 0; c < cycles; c++) stepCycle();
    endtask

    task automatic setOperands(input int lane, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
        req_a[lane*WIDTH +: WIDTH] = a;
        req_b[lane*WIDTH +: WIDTH] = b;
    endtask

    // Wait (bounded) for the accept pulse, check it is for 'lane', then drop
    // that lane's valid as a well-behaved requester would.
    task automatic waitGrant(input string tag, input int lane);
        logic [NREQ-1:0] want;
        want = '0;
        want[lane] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            stepCycle();
            if (req_ready != '0) begin
                checkOutput(tag, 32'(req_ready), 32'(want));
                req_valid[lane] = 1'b0;
                return;
            end
        end
        checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Wait (bounded) for the first rsp_valid and check its tag and product.
    task automatic waitResponse(input string tag, input int exp_id, input int exp_prod);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                checkOutput({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
                checkOutput({tag, "_product"}, 32'(rsp_product), 32'(exp_prod));
                return;
            end
        end
        checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // -----------------------------------------------------------------------
    // Behavioural reference model. 'stage' counts where the pending operation
    // is: 0 nothing in flight, 1 the cycle right after a grant, 2 response
    // offered. Inputs are captured at each falling edge and applied to the
    // model at the falling edge after the rising edge that consumed them.
    // -----------------------------------------------------------------------
    logic                  started = 1'b0;
    logic                  rst_s;
    logic [NREQ-1:0]       valid_s;
    logic [NREQ*WIDTH-1:0] a_s;
    logic [NREQ*WIDTH-1:0] b_s;
    logic                  rdy_s;
    int                    stage;
    int                    mptr;
    int                    exp_id;
    int                    exp_prod;
    logic [NREQ-1:0]       exp_ready;
    logic                  was_reset;

    always @(negedge clk) begin
        if (started) begin
            exp_ready = '0;
            if (rst_s !== 1'b1) begin
                stage     = 0;
                mptr      = 0;
                exp_id    = 0;
                exp_prod  = 0;
                was_reset = 1'b1;
            end else begin
                was_reset = 1'b0;
                if (stage == 0) begin
                    if (valid_s != '0) begin
                        int g;
                        g = -1;
                        for (int k = 0; k < NREQ; k++) begin
                            int j;
                            j = (mptr + k) % NREQ;
                            if (g < 0 && valid_s[j]) g = j;
                        end
                        exp_id       = g;
                        exp_prod     = int'(a_s[g*WIDTH +: WIDTH]) * int'(b_s[g*WIDTH +: WIDTH]);
                        mptr         = (g + 1) % NREQ;
                        exp_ready[g] = 1'b1;
                        stage        = 1;
                    end
                end else if (stage == 1) begin
                    stage = 2;
                end else if (rdy_s) begin
                    stage = 0;
                end
            end
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("rsp_valid", 32'(rsp_valid), (stage == 2) ? 32'd1 : 32'd0);
            checkOutput("busy", 32'(busy), (stage != 0) ? 32'd1 : 32'd0);
            if (stage == 2 || was_reset) begin
                checkOutput("rsp_id", 32'(rsp_id), 32'(exp_id));
                checkOutput("rsp_product", 32'(rsp_product), 32'(exp_prod));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] === 1'b1) grant_log.push_back(i);
            end
        end
        rst_s   = rst_n;
        valid_s = req_valid;
        a_s     = req_a;
        b_s     = req_b;
        rdy_s   = rsp_ready;
        started = 1'b1;
    end

    task automatic checkGrantOrder(input string tag, input int expected[5]);
        checkOutput({tag, "_count"}, (grant_log.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            checkOutput(tag, 32'(grant_log[i]), 32'(expected[i]));
        end
    endtask

    initial begin
        int rr_order[5];
        rr_order = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) setOperands(i, WIDTH'(i + 1), WIDTH'(i + 3));

        // Reset held three cycles with every requester asserting.
        applyStimulus('1, 1'b1, 3);
        @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        stepCycle();

        // Release: continuous requests must be served 0,1,2,3,0.
        grant_log.delete();
        rst_n = 1'b1;
        applyStimulus('1, 1'b1, 16);
        checkGrantOrder("rr_order", rr_order);

        // Single op on requester 2.
        applyStimulus('0, 1'b1, 5);
        setOperands(2, 4'd7, 4'd9);
        req_valid = 4'b0100;
        waitGrant("single_ready", 2);
        waitResponse("single", 2, 63);

        // Back-pressure with the maximum product, other requesters waiting.
        applyStimulus('0, 1'b1, 5);
        rsp_ready = 1'b0;
        setOperands(1, 4'hF, 4'hF);
        req_valid = 4'b0010;
        waitGrant("bp_ready", 1);
        req_valid = 4'b1101;
        waitResponse("bp", 1, 225);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("bp_hold_product", 32'(rsp_product), 32'd225);
            checkOutput("bp_no_accept", 32'(req_ready), 32'd0);
        end
        stepCycle();
        req_valid = '0;
        rsp_ready = 1'b1;
        applyStimulus('0, 1'b1, 12);

        // Zero operand on requester 3.
        setOperands(3, 4'd0, 4'hA);
        req_valid = 4'b1000;
        waitGrant("zero_ready", 3);
        waitResponse("zero", 3, 0);
        applyStimulus('0, 1'b1, 5);

        // Reset during CALC: the op vanishes and the pointer returns to 0.
        req_valid = 4'b0010;
        waitGrant("midop_ready", 1);
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("midop_no_rsp", 32'(rsp_valid), 32'd0);
        end
        stepCycle();
        grant_log.delete();
        applyStimulus('1, 1'b1, 3);
        checkOutput("midop_ptr_count", (grant_log.size() >= 1) ? 32'd1 : 32'd0, 32'd1);
        if (grant_log.size() >= 1) checkOutput("midop_ptr", 32'(grant_log[0]), 32'd0);
        applyStimulus('0, 1'b1, 5);

        // Randomized traffic: operands change only once a lane is idle or
        // has just been accepted.
        for (int n = 0; n < 400; n++) begin
            stepCycle();
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] || !req_valid[i]) begin
                    setOperands(i, WIDTH'($urandom), WIDTH'($urandom));
                    req_valid[i] = ($urandom % 3) != 0;
                end
            end
            rsp_ready = ($urandom % 4) != 0;
        end
        applyStimulus('0, 1'b1, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
